zap_btb_fb_gen: RTL and testbench
=================================

// Module: zap_btb_fb_gen
// PURPOSE
//  Branch-resolution feedback generator. It sits between the execute-stage branch resolver and the BTB.
//  - Per resolved branch: compares the prediction against the actual outcome and classifies it OK or NOK.
//  - Queues the feedback and drains it to the BTB's i_fb_* port, one entry per cycle.
//  - Raises a registered fetch redirect on every misprediction.
//  - Withholds feedback while the BTB is being cleared, so no update is lost.
// PARAMETERS
//  FIFO_DEPTH  4  feedback queue entries; power of two, >=2
// PORTS
//  i_clk                      in   1   clock
//  i_reset                    in   1   synchronous active-high reset
//  i_res_valid                in   1   resolved branch this cycle
//  i_res_pc                   in   32  branch source address
//  i_res_thumb                in   1   branch in 16-bit state
//  i_res_pred_state           in   2   BTB state the branch was predicted with
//  i_res_pred_target          in   32  predicted target
//  i_res_taken                in   1   actual direction
//  i_res_target               in   32  actual target
//  i_btb_clear                in   1   same signal driving BTB i_clear
//  o_fb_ok                    out  1   feedback valid, prediction correct
//  o_fb_nok                   out  1   feedback valid, mispredicted
//  o_fb_branch_src_address    out  32  head-entry pc
//  o_fb_current_branch_state  out  2   head-entry pred_state
//  o_fb_branch_dest_address   out  32  head-entry actual target
//  o_redirect                 out  1   one-cycle mispredict redirect pulse
//  o_redirect_pc              out  32  correct next fetch address
//  o_fifo_full                out  1   queue full
//  o_drop_count               out  16  saturating count of dropped feedback
// BEHAVIOUR
//  - Reset: queue empty, rd/wr pointers 0, all outputs 0.
//  - Encoding and predicted direction:
//    - State codes are SNT=00, WNT=01, WT=10, ST=11.
//    - pred_taken = (pred_state==WT || pred_state==ST).
//  - Classification, in cycle N of i_res_valid:
//    - nok = (pred_taken != i_res_taken) | (i_res_taken & pred_target != i_res_target).
//    - ok = !nok.
//  - Queue entry = {pc, pred_state, i_res_target, nok}.
//  - Push: an entry is written at the end of cycle N when (!full | pop).
//    - A push to a full queue with a simultaneous pop is accepted.
//  - Drop: a push to a full queue without a pop is dropped.
//    - o_drop_count increments by 1 and saturates at 16'hFFFF.
//  - Output timing:
//    - o_fb_* are combinational from the queue head, so the earliest feedback is cycle N+1.
//    - There is no same-cycle bypass.
//  - Feedback qualifiers:
//    - o_fb_ok = !empty & !nok_head & !i_btb_clear.
//    - o_fb_nok = !empty & nok_head & !i_btb_clear.
//    - ok and nok are never both high.
//  - Pop happens when (o_fb_ok|o_fb_nok): one entry per cycle, and the BTB always accepts.
//    - While i_btb_clear=1 there is no pop and the entry is held.
//    - The data outputs still show the head entry.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//    - full = MSBs differ and the rest are equal; empty = pointers equal.
//    - o_fifo_full is registered full state.
//  - Redirect:
//    - Registered. o_redirect=1 in cycle N+1 only when nok, otherwise 0.
//    - o_redirect_pc = i_res_taken ? i_res_target : i_res_pc + (i_res_thumb ? 2 : 4), captured in cycle N.
//    - o_redirect_pc holds its value when o_redirect=0.
//    - The redirect is issued even if the feedback entry is dropped.
//  - i_btb_clear does not flush the queue: resolved branches are architectural fact.
//  - Reset mid-operation discards all queued entries. o_drop_count returns to 0.
//  - Addition wraps modulo 2^32.
// TESTING
//  1. Correct-taken prediction: pred_state=ST, pred_target=target=0x100, taken=1, pc=0x80
//     -> cycle N+1: o_fb_ok=1, src=0x80, state=11, dest=0x100, o_redirect=0.
//  2. Direction mispredict: pred_state=WNT, taken=1, target=0x200, pc=0x40
//     -> o_fb_nok=1, o_redirect=1, o_redirect_pc=0x200.
//  3. Not-taken mispredict in Thumb: pred_state=WT, taken=0, pc=0x1000, thumb=1
//     -> o_redirect_pc=0x1002; in ARM state -> 0x1004.
//  4. Clear hold: queue one entry, assert i_btb_clear for 3 cycles
//     -> ok/nok=0 for 3 cycles, entry delivered the cycle after clear drops.
//  5. Overflow: hold i_btb_clear, push FIFO_DEPTH+2 branches
//     -> o_fifo_full=1, o_drop_count=2, FIFO_DEPTH entries drain in order after clear.
//  6. Reset with 3 entries queued -> next cycle empty, ok/nok=0, o_drop_count=0.

Source files
------------

// File: rtl/zap_btb_fb_gen.sv
// Branch-resolution feedback generator: classifies resolved branches, queues
// BTB update feedback, and issues a registered fetch redirect on mispredicts.
module zap_btb_fb_gen #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_res_valid,
  input  logic [31:0] i_res_pc,
  input  logic        i_res_thumb,
  input  logic [1:0]  i_res_pred_state,
  input  logic [31:0] i_res_pred_target,
  input  logic        i_res_taken,
  input  logic [31:0] i_res_target,
  input  logic        i_btb_clear,
  output logic        o_fb_ok,
  output logic        o_fb_nok,
  output logic [31:0] o_fb_branch_src_address,
  output logic [1:0]  o_fb_current_branch_state,
  output logic [31:0] o_fb_branch_dest_address,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_fifo_full,
  output logic [15:0] o_drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  st;
    logic [31:0] tgt;
    logic        nok;
  } entry_t;

  entry_t      mem_q [FIFO_DEPTH];
  entry_t      mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic   pred_taken, nok, empty, full, fb_vld, pop, push, drop;
  entry_t head;

  // Predicted taken for WT (10) and ST (11): the state MSB.
  assign pred_taken = i_res_pred_state[1];
  assign nok   = (pred_taken != i_res_taken) |
                 (i_res_taken & (i_res_pred_target != i_res_target));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Feedback is withheld during a BTB clear so the update is not lost.
  assign fb_vld = !empty & !i_btb_clear;
  assign pop    = fb_vld;
  assign push   = i_res_valid & (!full | pop);
  assign drop   = i_res_valid & full & !pop;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    redirect_d    = i_res_valid & nok;
    redirect_pc_d = redirect_pc_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{pc: i_res_pc, st: i_res_pred_state,
                                  tgt: i_res_target, nok: nok};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (i_res_valid && nok)
      redirect_pc_d = i_res_taken ? i_res_target
                                  : i_res_pc + (i_res_thumb ? 32'd2 : 32'd4);
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
             (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      full_q        <= 1'b0;
      drop_cnt_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_q        <= full_d;
      drop_cnt_q    <= drop_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_fb_ok                   = fb_vld & !head.nok;
  assign o_fb_nok                  = fb_vld & head.nok;
  assign o_fb_branch_src_address   = head.pc;
  assign o_fb_current_branch_state = head.st;
  assign o_fb_branch_dest_address  = head.tgt;
  assign o_redirect                = redirect_q;
  assign o_redirect_pc             = redirect_pc_q;
  assign o_fifo_full               = full_q;
  assign o_drop_count              = drop_cnt_q;

endmodule

// File: tb/tb_zap_btb_fb_gen.sv
// Directed bench for zap_btb_fb_gen: stimulus pushes expected feedback and
// redirects into queues; negedge monitors pop and compare.
module tb_zap_btb_fb_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_thumb;
  logic [1:0]  res_pred_state;
  logic [31:0] res_pred_target;
  logic        res_taken;
  logic [31:0] res_target;
  logic        btb_clear;
  logic        fb_ok, fb_nok;
  logic [31:0] fb_src, fb_dest;
  logic [1:0]  fb_state;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fifo_full;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // {nok, pc, state, dest}
  logic [66:0] exp_q[$];
  logic [31:0] redir_q[$];

  zap_btb_fb_gen #(.FIFO_DEPTH(4)) dut (
    .i_clk                     (clk),
    .i_reset                   (rst),
    .i_res_valid               (res_valid),
    .i_res_pc                  (res_pc),
    .i_res_thumb               (res_thumb),
    .i_res_pred_state          (res_pred_state),
    .i_res_pred_target         (res_pred_target),
    .i_res_taken               (res_taken),
    .i_res_target              (res_target),
    .i_btb_clear               (btb_clear),
    .o_fb_ok                   (fb_ok),
    .o_fb_nok                  (fb_nok),
    .o_fb_branch_src_address   (fb_src),
    .o_fb_current_branch_state (fb_state),
    .o_fb_branch_dest_address  (fb_dest),
    .o_redirect                (redirect),
    .o_redirect_pc             (redirect_pc),
    .o_fifo_full               (fifo_full),
    .o_drop_count              (drop_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Driver: one resolved branch for one cycle; expectations are hand-computed.
  task automatic res(input logic [31:0] pc, input logic thumb, input logic [1:0] st,
                     input logic [31:0] ptgt, input logic taken, input logic [31:0] tgt,
                     input logic exp_nok, input logic [31:0] exp_rpc, input logic accept);
    res_valid = 1'b1; res_pc = pc; res_thumb = thumb; res_pred_state = st;
    res_pred_target = ptgt; res_taken = taken; res_target = tgt;
    if (accept) exp_q.push_back({exp_nok, pc, st, tgt});
    if (exp_nok) redir_q.push_back(exp_rpc);
    sync();
    res_valid = 1'b0;
  endtask

  // Feedback monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_ok && fb_nok) check("ok_nok_exclusive", 32'd1, 32'd0);
      if (fb_ok || fb_nok) begin
        if (exp_q.size() == 0) begin
          check("fb_unexpected", {fb_nok, fb_src[30:0]}, 32'd0);
        end else begin
          logic [66:0] e;
          e = exp_q.pop_front();
          check("fb_nok", {31'd0, fb_nok}, {31'd0, e[66]});
          check("fb_src", fb_src, e[65:34]);
          check("fb_state", {30'd0, fb_state}, {30'd0, e[33:32]});
          check("fb_dest", fb_dest, e[31:0]);
        end
      end
    end
  end

  // Redirect monitor
  always @(negedge clk) begin
    if (!rst && redirect) begin
      if (redir_q.size() == 0) check("redirect_unexpected", redirect_pc, 32'hFFFF_FFFF);
      else check("redirect_pc", redirect_pc, redir_q.pop_front());
    end
  end

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      sync();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_thumb = 1'b0;
    res_pred_state = '0; res_pred_target = '0; res_taken = 1'b0;
    res_target = '0; btb_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ok", {31'd0, fb_ok}, 0);
    check("reset_nok", {31'd0, fb_nok}, 0);
    check("reset_src", fb_src, 0);
    check("reset_redirect", {31'd0, redirect}, 0);
    check("reset_full", {31'd0, fifo_full}, 0);
    check("reset_drop", {16'd0, drop_count}, 0);
    sync();

    // Correct-taken, direction mispredict, Thumb/ARM not-taken mispredicts
    res(32'h80, 0, 2'b11, 32'h100, 1, 32'h100, 0, 32'h0, 1);
    res(32'h40, 0, 2'b01, 32'h0, 1, 32'h200, 1, 32'h200, 1);
    res(32'h800, 0, 2'b00, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    check("redirect_pc_hold", redirect_pc, 32'h200);
    res(32'h1000, 1, 2'b10, 32'h0, 0, 32'h0, 1, 32'h1002, 1);
    res(32'h1000, 0, 2'b10, 32'h0, 0, 32'h0, 1, 32'h1004, 1);
    // Target mismatch with correct direction, and pc wrap
    res(32'h300, 0, 2'b11, 32'h400, 1, 32'h500, 1, 32'h500, 1);
    res(32'hFFFF_FFFE, 1, 2'b11, 32'h0, 0, 32'h0, 1, 32'h0, 1);
    res(32'h600, 0, 2'b01, 32'h0, 0, 32'h700, 0, 32'h0, 1);
    drain("drain_basic");

    // Clear hold: entry withheld for 3 cycles, delivered after clear drops
    btb_clear = 1'b1;
    res(32'h2000, 0, 2'b10, 32'h2100, 1, 32'h2100, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clear_ok", {31'd0, fb_ok}, 0);
      check("clear_nok", {31'd0, fb_nok}, 0);
      check("clear_src_visible", fb_src, 32'h2000);
      if (i < 2) sync();
    end
    @(posedge clk);
    #1 btb_clear = 1'b0;
    @(negedge clk);
    check("clear_release_ok", {31'd0, fb_ok}, 1);
    sync();
    check("clear_delivered", exp_q.size(), 0);

    // Overflow under clear: 4 accepted, 2 dropped
    btb_clear = 1'b1;
    for (int i = 0; i < 6; i++)
      res(32'h3000 + 32'(i * 16), 0, 2'b00, 32'h0, 0, 32'h3800 + 32'(i), 0, 32'h0, i < 4);
    check("ovf_full", {31'd0, fifo_full}, 1);
    check("ovf_drop", {16'd0, drop_count}, 2);
    btb_clear = 1'b0;
    drain("drain_ovf");
    check("ovf_not_full", {31'd0, fifo_full}, 0);

    // Reset with 3 entries queued
    btb_clear = 1'b1;
    for (int i = 0; i < 3; i++)
      res(32'h5000 + 32'(i * 4), 0, 2'b11, 32'h5100, 1, 32'h5100, 0, 32'h0, 1);
    exp_q.delete();
    rst = 1'b1; btb_clear = 1'b0;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ok", {31'd0, fb_ok}, 0);
    check("rst_nok", {31'd0, fb_nok}, 0);
    check("rst_drop", {16'd0, drop_count}, 0);
    check("rst_full", {31'd0, fifo_full}, 0);
    sync();
    res(32'h6000, 0, 2'b01, 32'h0, 1, 32'h6400, 1, 32'h6400, 1);
    drain("drain_post_reset");
    sync();
    check("redir_q_empty", redir_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
